// File: rtl/miner_spi_pkg.sv
// miner_spi_pkg: shared constants and FSM encoding for the miner SPI status poller
package miner_spi_pkg;

    localparam logic [7:0] WAITING          = 8'hA0;
    localparam logic [7:0] POLL_CMD_DEFAULT = 8'hF0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_DESEL = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    // States during which the slave is selected
    function automatic logic ssel_active(input logic [2:0] st);
        return st inside {ST_SETUP, ST_XFER, ST_GAP, ST_HOLD};
    endfunction

endpackage

// File: rtl/spi_master_byte.sv
// spi_master_byte: shifts one byte out on mosi and in from miso, SPI mode 0, MSB first
module spi_master_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sck,
    output logic       mosi
);

    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic          active_q, active_d;
    logic          sck_q, sck_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    rx_q, rx_d;
    logic          phase_end;

    assign phase_end = active_q && div_q == DIV_LAST;
    assign byte_done = phase_end && sck_q && bit_q == 3'd7;
    assign rx_byte   = rx_q;
    assign sck       = sck_q;
    assign mosi      = active_q & tx_q[7];

    // Next state: sample miso as sck is driven high, shift mosi as sck is driven low
    always_comb begin
        active_d = start ? 1'b1 : active_q && !byte_done;
        div_d    = start || phase_end ? '0 : active_q ? div_q + 1'b1 : div_q;
        sck_d    = start ? 1'b0 : phase_end ? !sck_q : sck_q;
        bit_d    = start ? 3'd0 : phase_end && sck_q ? bit_q + 3'd1 : bit_q;
        tx_d     = start ? tx_byte : phase_end && sck_q ? {tx_q[6:0], 1'b0} : tx_q;
        rx_d     = phase_end && !sck_q ? {rx_q[6:0], miso} : rx_q;
    end

    // Shifter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 8'h00;
            rx_q     <= 8'h00;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

endmodule

// File: rtl/spi_poll_master.sv
// spi_poll_master: issues one SPI status poll per start and latches the last received byte
module spi_poll_master
    import miner_spi_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         RESP_BYTES = 2,
    parameter logic [7:0] POLL_CMD   = POLL_CMD_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       poll_start,
    output logic       poll_busy,
    output logic       poll_done,
    output logic [7:0] status,
    output logic       status_waiting,
    output logic       sck,
    output logic       mosi,
    input  logic       miso,
    output logic       ssel
);

    localparam int            N          = 1 + RESP_BYTES;
    localparam int            CW         = $clog2(CLK_DIV);
    localparam int            BW         = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLK_DIV - 1);
    // The DONE cycle is the final deselected cycle, so DESEL itself runs one short
    localparam logic [CW-1:0] DESEL_LAST = CW'(CLK_DIV - 2);
    localparam logic [BW-1:0] BYTE_LAST  = BW'(N - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          ssel_q, ssel_d;
    logic [7:0]    status_q, status_d;
    logic          timed, cnt_last, byte_start, byte_done, byte_sck, byte_mosi;
    logic [7:0]    rx_byte;

    assign timed      = state_q inside {ST_SETUP, ST_GAP, ST_HOLD, ST_DESEL};
    assign cnt_last   = cnt_q == (state_q == ST_DESEL ? DESEL_LAST : CNT_LAST);
    assign byte_start = (state_q == ST_SETUP || state_q == ST_GAP) && cnt_last;

    spi_master_byte #(.CLK_DIV(CLK_DIV)) u_byte (
        .clk      (clk),
        .reset    (reset),
        .start    (byte_start),
        .tx_byte  (byte_q == '0 ? POLL_CMD : 8'h00),
        .miso     (miso),
        .rx_byte  (rx_byte),
        .byte_done(byte_done),
        .sck      (byte_sck),
        .mosi     (byte_mosi)
    );

    // Sequencing of select, inter-byte gap, hold and deselect phases
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:          if (poll_start) state_d = ST_SETUP;
            ST_SETUP, ST_GAP: if (cnt_last) state_d = ST_XFER;
            ST_XFER:          if (byte_done) state_d = byte_q == BYTE_LAST ? ST_HOLD : ST_GAP;
            ST_HOLD:          if (cnt_last) state_d = ST_DESEL;
            ST_DESEL:         if (cnt_last) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
        cnt_d    = timed && !cnt_last ? cnt_q + 1'b1 : '0;
        byte_d   = byte_done ? (byte_q == BYTE_LAST ? '0 : byte_q + 1'b1) : byte_q;
        ssel_d   = !ssel_active(state_d);
        status_d = state_q == ST_DESEL && cnt_last ? rx_byte : status_q;
    end

    // Controller registers; status only moves on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            byte_q   <= '0;
            ssel_q   <= 1'b1;
            status_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            byte_q   <= byte_d;
            ssel_q   <= ssel_d;
            status_q <= status_d;
        end
    end

    assign poll_busy      = state_q != ST_IDLE;
    assign poll_done      = state_q == ST_DONE;
    assign status         = status_q;
    assign status_waiting = status_q == WAITING;
    assign sck            = byte_sck;
    assign mosi           = state_q == ST_SETUP ? POLL_CMD[7] : byte_mosi;
    assign ssel           = ssel_q;

endmodule

// File: tb/tb_spi_poll_master.sv
// tb_spi_poll_master: randomized scoreboard bench with a behavioural SPI slave
module tb_spi_poll_master;

    localparam int LA = 212;
    localparam int LB = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a = 1'b1, start_a = 1'b0, miso_a;
    logic       busy_a, done_a, wait_a, sck_a, mosi_a, ssel_a;
    logic [7:0] status_a;
    logic       rst_b = 1'b1, start_b = 1'b0, miso_b;
    logic       busy_b, done_b, wait_b, sck_b, mosi_b, ssel_b;
    logic [7:0] status_b;

    spi_poll_master dut_a (
        .clk(clk), .reset(rst_a), .poll_start(start_a), .poll_busy(busy_a), .poll_done(done_a),
        .status(status_a), .status_waiting(wait_a), .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .ssel(ssel_a)
    );

    spi_poll_master #(.CLK_DIV(2), .RESP_BYTES(1)) dut_b (
        .clk(clk), .reset(rst_b), .poll_start(start_b), .poll_busy(busy_b), .poll_done(done_b),
        .status(status_b), .status_waiting(wait_b), .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .ssel(ssel_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [7:0] pick();
        int s = $urandom_range(3);
        return s == 0 ? 8'hA0 : s == 1 ? 8'h5A : s == 2 ? 8'hFF : 8'($urandom);
    endfunction

    // ---------------- instance A: defaults (CLK_DIV 4, 3 bytes) ----------------
    logic [7:0]  exp_st_a[$];
    int          exp_t_a[$];
    int          free_a = 0, dones_a = 0, falls_a = 0, hi_a = 0;
    logic [31:0] load_a = 0, sr_a = 0;
    logic [23:0] mosi_sr_a = 0;
    logic        armed_a = 1'b1, rstq_a = 1'b1, sck_p_a = 1'b0, mosi_p_a = 1'b0;
    logic [7:0]  st_p_a = 0;

    assign miso_a = sr_a[31];
    always @(posedge clk) rstq_a <= rst_a;

    always @(ssel_a, sck_a) begin
        if (ssel_a !== 1'b0) armed_a = 1'b1;
        else if (armed_a) begin
            armed_a = 1'b0;
            sr_a = load_a;
            falls_a++;
        end else if (sck_a === 1'b0) sr_a = sr_a << 1;
    end

    always @(posedge sck_a) mosi_sr_a = {mosi_sr_a[22:0], mosi_a};

    always @(negedge clk) begin
        logic [7:0] st;
        if (done_a) begin
            dones_a++;
            chk("a_done_expected", exp_st_a.size() > 0, 1);
            if (exp_st_a.size() > 0) begin
                st = exp_st_a.pop_front();
                chk("a_latency", cyc - exp_t_a.pop_front(), LA);
                chk("a_status", status_a, st);
                chk("a_status_waiting", wait_a, st == 8'hA0);
                chk("a_mosi_bytes", mosi_sr_a, 24'hF00000);
            end
        end
        if (status_a !== st_p_a) chk("a_status_only_at_done", done_a || rstq_a, 1);
        if (sck_a) hi_a++;
        else if (sck_p_a) begin
            if (!rstq_a) chk("a_sck_high_cycles", hi_a, 4);
            hi_a = 0;
        end
        if (sck_a && sck_p_a) chk("a_mosi_stable_high", mosi_a, mosi_p_a);
        st_p_a = status_a;
        sck_p_a = sck_a;
        mosi_p_a = mosi_a;
    end

    task automatic pulse_a(input logic [7:0] r1, input logic [7:0] r2);
        if (cyc >= free_a) begin
            load_a = {8'($urandom), r1, r2, 8'h00};
            exp_st_a.push_back(r2);
            exp_t_a.push_back(cyc);
            free_a = cyc + LA + 1;
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic run_a();
        int k, d0, f0;
        repeat (3) @(negedge clk);
        chk("a_rst_ssel", ssel_a, 1);
        chk("a_rst_sck", sck_a, 0);
        chk("a_rst_mosi", mosi_a, 0);
        chk("a_rst_busy", busy_a, 0);
        chk("a_rst_done", done_a, 0);
        chk("a_rst_status", status_a, 0);
        chk("a_rst_waiting", wait_a, 0);
        rst_a = 1'b0;
        @(negedge clk);
        pulse_a(8'hA0, 8'hA0);
        chk("a_busy_after_start", busy_a, 1);
        wait_until(free_a);
        chk("a_idle_after_done", busy_a, 0);
        pulse_a(8'hFF, 8'h5A);
        wait_until(free_a);
        k = cyc;
        d0 = dones_a;
        f0 = falls_a;
        pulse_a(8'hA0, 8'hA0);
        wait_until(k + 10);
        pulse_a(pick(), pick());
        wait_until(k + 100);
        pulse_a(pick(), pick());
        wait_until(free_a + 2);
        chk("a_repeat_one_done", dones_a - d0, 1);
        chk("a_repeat_one_ssel_low", falls_a - f0, 1);
        k = cyc;
        pulse_a(pick(), pick());
        wait_until(k + LA);
        chk("a_done_cycle", done_a, 1);
        pulse_a(pick(), pick());
        pulse_a(pick(), pick());
        wait_until(free_a);
        repeat (4) begin
            repeat ($urandom_range(5)) @(negedge clk);
            k = cyc;
            pulse_a(pick(), pick());
            if ($urandom_range(1) == 1) begin
                wait_until(k + $urandom_range(2, 200));
                pulse_a(pick(), pick());
            end
            wait_until(free_a);
        end
        k = cyc;
        d0 = dones_a;
        pulse_a(8'hA0, 8'h5A);
        wait_until(k + 90);
        rst_a = 1'b1;
        exp_st_a.delete();
        exp_t_a.delete();
        free_a = 0;
        @(negedge clk);
        chk("a_abort_ssel", ssel_a, 1);
        chk("a_abort_sck", sck_a, 0);
        chk("a_abort_busy", busy_a, 0);
        chk("a_abort_status", status_a, 0);
        rst_a = 1'b0;
        repeat (300) @(negedge clk);
        chk("a_abort_no_done", dones_a - d0, 0);
        pulse_a(8'h5A, 8'hA0);
        wait_until(free_a);
        chk("a_no_pending", exp_st_a.size(), 0);
    endtask

    // ---------------- instance B: CLK_DIV 2, 2 bytes ----------------
    logic [7:0]  exp_st_b[$];
    int          exp_t_b[$];
    int          free_b = 0, hi_b = 0;
    logic [31:0] load_b = 0, sr_b = 0;
    logic [15:0] mosi_sr_b = 0;
    logic        armed_b = 1'b1, rstq_b = 1'b1, sck_p_b = 1'b0, mosi_p_b = 1'b0;

    assign miso_b = sr_b[31];
    always @(posedge clk) rstq_b <= rst_b;

    always @(ssel_b, sck_b) begin
        if (ssel_b !== 1'b0) armed_b = 1'b1;
        else if (armed_b) begin
            armed_b = 1'b0;
            sr_b = load_b;
        end else if (sck_b === 1'b0) sr_b = sr_b << 1;
    end

    always @(posedge sck_b) mosi_sr_b = {mosi_sr_b[14:0], mosi_b};

    always @(negedge clk) begin
        logic [7:0] st;
        if (done_b) begin
            chk("b_done_expected", exp_st_b.size() > 0, 1);
            if (exp_st_b.size() > 0) begin
                st = exp_st_b.pop_front();
                chk("b_latency", cyc - exp_t_b.pop_front(), LB);
                chk("b_status", status_b, st);
                chk("b_status_waiting", wait_b, st == 8'hA0);
                chk("b_mosi_bytes", mosi_sr_b, 16'hF000);
            end
        end
        if (sck_b) hi_b++;
        else if (sck_p_b) begin
            if (!rstq_b) chk("b_sck_high_cycles", hi_b, 2);
            hi_b = 0;
        end
        if (sck_b && sck_p_b) chk("b_mosi_stable_high", mosi_b, mosi_p_b);
        sck_p_b = sck_b;
        mosi_p_b = mosi_b;
    end

    task automatic pulse_b(input logic [7:0] r1);
        if (cyc >= free_b) begin
            load_b = {8'($urandom), r1, 16'h0000};
            exp_st_b.push_back(r1);
            exp_t_b.push_back(cyc);
            free_b = cyc + LB + 1;
        end
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
    endtask

    task automatic run_b();
        int k;
        repeat (2) @(negedge clk);
        chk("b_rst_ssel", ssel_b, 1);
        chk("b_rst_sck", sck_b, 0);
        rst_b = 1'b0;
        @(negedge clk);
        pulse_b(8'hA0);
        wait_until(free_b);
        repeat (5) begin
            repeat ($urandom_range(3)) @(negedge clk);
            k = cyc;
            pulse_b(pick());
            wait_until(k + $urandom_range(1, 60));
            pulse_b(pick());
            wait_until(free_b);
        end
        chk("b_no_pending", exp_st_b.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        fork
            run_a();
            run_b();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_poll_master.md
SPI_POLL_MASTER -- requirements
Module: spi_poll_master

Interface
REQ-001 Parameter CLK_DIV, default 4: sck half-period in clk cycles; legal values are >= 2.
REQ-002 Parameter RESP_BYTES, default 2: number of dummy bytes clocked after the command byte.
REQ-003 Parameter POLL_CMD, default 8'hF0: command byte sent first in every poll.
REQ-004 clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 poll_start  in  1  single-cycle request to start one poll transaction.
REQ-007 poll_busy  out  1  high from the cycle after an accepted start until the cycle of poll_done, inclusive.
REQ-008 poll_done  out  1  one-cycle pulse marking the end of a transaction.
REQ-009 status  out  8  last byte received in the most recent completed poll.
REQ-010 status_waiting  out  1  equals (status == WAITING).
REQ-011 sck  out  1  SPI clock, mode 0 (idles low).
REQ-012 mosi  out  1  master data out, MSB first.
REQ-013 miso  in  1  slave data in, MSB first.
REQ-014 ssel  out  1  slave select, active low.

Function
REQ-015 poll_start is accepted only in IDLE; a start while poll_busy is high shall be ignored, with no queuing.
REQ-016 The FSM shall use states IDLE -> SETUP -> XFER -> (GAP -> XFER)* -> HOLD -> DESEL -> DONE -> IDLE.
REQ-017 SETUP: ssel is driven low for CLK_DIV cycles with sck low; mosi presents the MSB of POLL_CMD.
REQ-018 XFER: 8 sck periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-019 In XFER, mosi shall change only while sck is low.
REQ-020 In XFER, miso shall be sampled in the clk cycle in which sck is driven high.
REQ-021 Byte order: byte 0 is POLL_CMD, followed by RESP_BYTES bytes of 8'h00; N = 1 + RESP_BYTES.
REQ-022 GAP: CLK_DIV cycles with sck low and ssel low between consecutive bytes.
REQ-023 HOLD: CLK_DIV cycles with ssel low after the last falling sck edge.
REQ-024 DESEL: CLK_DIV cycles with ssel high.
REQ-025 DONE: one cycle in which poll_done = 1 and status loads the last received byte.
REQ-026 status shall not change at any other time; partially shifted bytes are never visible on status.
REQ-027 Latency: poll_done shall assert exactly CLK_DIV*(17*N + 2) cycles after the accepting poll_start cycle; with the defaults this is 212 cycles.
REQ-028 The bit counter (3-bit) and byte counter shall wrap to 0 at the end of each byte and each transaction respectively.
REQ-029 poll_start asserted in the DONE cycle shall be ignored; poll_start asserted on the following cycle (IDLE) shall be accepted.

Reset
REQ-030 When reset is asserted: FSM goes to IDLE, sck = 0, ssel = 1, mosi = 0, poll_busy = 0, poll_done = 0, status = 8'h00, and all counters are cleared.
REQ-031 Reset mid-transaction shall abort the transaction: ssel is high and sck is low on the first edge after reset, no poll_done is produced, and status is cleared.
REQ-032 reset has priority over poll_start in the same cycle.

Structure
REQ-033 Shared package miner_spi_pkg shall hold WAITING = 8'hA0, the default POLL_CMD = 8'hF0, and the FSM state encoding.
REQ-034 Byte shifting shall be implemented in one sub-module, spi_master_byte (inputs: start, tx_byte; outputs: rx_byte, byte_done, sck, mosi), parameterized by CLK_DIV.
REQ-035 spi_poll_master shall own ssel, the SETUP/GAP/HOLD/DESEL timing, and the status register.

Verification
REQ-036 Bench slave model answers 8'hA0 in every byte after 8'hF0 is received; pulse start -> mosi bits decode to F0,00,00; status = 8'hA0; status_waiting = 1; done 212 cycles after start.
REQ-037 Slave model drives 8'h5A on the last byte -> status = 8'h5A, status_waiting = 0; an earlier 8'hFF byte is never visible on status.
REQ-038 Start pulses repeated while busy (cycles 10 and 100) -> exactly one poll_done; ssel makes exactly one low excursion.
REQ-039 Assert reset at cycle 90 of a poll -> next cycle ssel = 1, sck = 0, busy = 0, status = 0; no poll_done within the following 300 cycles.
REQ-040 CLK_DIV = 2, RESP_BYTES = 1 -> sck high and low phases are 2 cycles each; done at cycle 72; miso is stable at every rising sck edge.
REQ-041 Start in the DONE cycle, then start on the next cycle -> the first start is ignored, the second is accepted, and back-to-back polls both complete.
